// File: rtl/iterative_muldiv_unit.sv
// iterative_muldiv_unit: radix-2 shift-add multiplier / restoring divider, one operation in flight.
// Latency: WIDTH+1 edges counting the accept edge; 1 edge for trivial operands when early-out is built in.
// Backpressure: the result is held in DONE until OutReady; InReady is low while busy or holding.
//
// Ports:
//   Clk, ResetN          clock, asynchronous active-low reset
//   InValid / InReady    request handshake; Rs1, Rs2, CtrlMDOp are captured on accept
//   CtrlMDOp             0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   Kill                 synchronous abort from any state (wins over accept and OutReady)
//   OutValid / OutReady  result handshake; Rd reads 0 whenever OutValid is low
// Compile option: MDU_EARLY_OUT_EN - zero operands, divide-by-zero and signed overflow
//   finish straight from IDLE to DONE.
module iterative_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] Rs1,
  input  logic [WIDTH-1:0] Rs2,
  input  logic [2:0]       CtrlMDOp,
  input  logic             Kill,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Rd
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             qneg_q, qneg_d;   // negate product / quotient at the end
  logic             rneg_q, rneg_d;   // negate remainder at the end
  logic [WIDTH-1:0] hi_q, hi_d;       // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier shifting out / dividend->quotient
  logic [WIDTH-1:0] b_q, b_d;         // |multiplicand| or |divisor|
  logic [WIDTH-1:0] res_q, res_d;

  // ---------------- request decode ----------------
  logic             is_div_op, a_sgn, b_sgn;
  logic [WIDTH-1:0] abs_a, abs_b;

  always_comb begin
    is_div_op = CtrlMDOp[2];
    a_sgn = Rs1[WIDTH-1] && ((CtrlMDOp == OP_MULH) || (CtrlMDOp == OP_MULHSU) ||
                             (CtrlMDOp == OP_DIV)  || (CtrlMDOp == OP_REM));
    b_sgn = Rs2[WIDTH-1] && ((CtrlMDOp == OP_MULH) || (CtrlMDOp == OP_DIV) ||
                             (CtrlMDOp == OP_REM));
    abs_a = a_sgn ? -Rs1 : Rs1;
    abs_b = b_sgn ? -Rs2 : Rs2;
  end

`ifdef MDU_EARLY_OUT_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             ovf, early;
  logic [WIDTH-1:0] early_res;

  always_comb begin
    ovf   = ((CtrlMDOp == OP_DIV) || (CtrlMDOp == OP_REM)) && (Rs1 == MOST_NEG) && (&Rs2);
    early = (~|Rs1) || (~|Rs2) || ovf;
    // Any product with a zero operand and any quotient/remainder of a zero dividend is 0.
    early_res = '0;
    if (is_div_op) begin
      if (~|Rs2) begin
        early_res = CtrlMDOp[1] ? Rs1 : '1;   // REM/REMU return the dividend
      end else if (ovf) begin
        early_res = CtrlMDOp[1] ? '0 : Rs1;
      end
    end
  end
`endif

  // ---------------- one radix-2 step ----------------
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] it_hi, it_lo;

  always_comb begin
    // Multiply: add multiplicand when the multiplier LSB is set, then shift {carry,hi,lo} right.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // Divide: shift next dividend bit into the remainder and subtract if it fits.
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    div_ge  = rem_sh >= {1'b0, b_q};
    if (op_q[2]) begin
      it_hi = div_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // ---------------- sign correction of the final step ----------------
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fin_res;

  always_comb begin
    prod     = {it_hi, it_lo};
    prod_fix = qneg_q ? -prod : prod;
    quo_fix  = qneg_q ? -it_lo : it_lo;
    rem_fix  = rneg_q ? -it_hi : it_hi;
    case (op_q)
      OP_MUL:                       fin_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fin_res = quo_fix;
      default:                      fin_res = rem_fix;
    endcase
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    res_d   = res_q;

    if (Kill) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      res_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (InValid) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            op_d    = CtrlMDOp;
            // A zero divisor keeps the all-ones quotient unnegated.
            qneg_d  = (a_sgn ^ b_sgn) && (|Rs2);
            rneg_d  = a_sgn;
            hi_d    = '0;
            lo_d    = is_div_op ? abs_a : abs_b;
            b_d     = is_div_op ? abs_b : abs_a;
`ifdef MDU_EARLY_OUT_EN
            if (early) begin
              state_d = S_DONE;
              res_d   = early_res;
            end
`endif
          end
        end
        S_BUSY: begin
          hi_d = it_hi;
          lo_d = it_lo;
          if (cnt_q == LAST_ITER) begin
            state_d = S_DONE;
            cnt_d   = '0;
            res_d   = fin_res;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (OutReady) begin
            state_d = S_IDLE;
            res_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          res_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign InReady  = (state_q == S_IDLE);
  assign OutValid = (state_q == S_DONE);
  assign Rd       = OutValid ? res_q : '0;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// tb_iterative_muldiv_unit: directed and randomized checks of iterative_muldiv_unit
// against an arithmetic reference model, for WIDTH=32 and WIDTH=8 instances.
// Latency is counted in edges from the accept edge (inclusive) to OutValid.
module tb_iterative_muldiv_unit;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        ResetN;
  logic        InValid, InReady, Kill, OutValid, OutReady;
  logic [31:0] Rs1, Rs2, Rd;
  logic [2:0]  CtrlMDOp;

  logic        InValid8, InReady8, Kill8, OutValid8, OutReady8;
  logic [7:0]  Rs1_8, Rs2_8, Rd8;
  logic [2:0]  Op8;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  iterative_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
    .Rs1(Rs1), .Rs2(Rs2), .CtrlMDOp(CtrlMDOp), .Kill(Kill),
    .OutValid(OutValid), .OutReady(OutReady), .Rd(Rd)
  );

  iterative_muldiv_unit #(.WIDTH(8)) dut8 (
    .Clk(Clk), .ResetN(ResetN), .InValid(InValid8), .InReady(InReady8),
    .Rs1(Rs1_8), .Rs2(Rs2_8), .CtrlMDOp(Op8), .Kill(Kill8),
    .OutValid(OutValid8), .OutReady(OutReady8), .Rd(Rd8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on sign-/zero-extended operands (w <= 32).
  function automatic logic [63:0] ref_model(input int w, input logic [2:0] op,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, ua_l, ub_l, tmp;
    longint ua, ub, sa, sb, r;
    mask = (64'd1 << w) - 64'd1;
    ua_l = a_in & mask;
    ub_l = b_in & mask;
    ua = longint'(ua_l);
    ub = longint'(ub_l);
    sa = a_in[w-1] ? ua - longint'(64'd1 << w) : ua;
    sb = b_in[w-1] ? ub - longint'(64'd1 << w) : ub;
    case (op)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >> w;
      3'd2: r = (sa * ub) >> w;
      3'd3: begin tmp = ua_l * ub_l; r = longint'(tmp >> w); end
      3'd4: r = (ub == 0) ? -1 : sa / sb;
      3'd5: r = (ub == 0) ? -1 : ua / ub;
      3'd6: r = (ub == 0) ? sa : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 64'(r) & mask;
  endfunction

  function automatic int exp_lat(input int w, input logic [2:0] op,
                                 input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b;
    bit trivial;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    trivial = (a == 0) || (b == 0) ||
              (((op == 3'd4) || (op == 3'd6)) && (a == (64'd1 << (w - 1))) && (b == mask));
    return (EARLY && trivial) ? 1 : w + 1;
  endfunction

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    check("inready_before_accept", InReady, 1);
    Rs1 = a; Rs2 = b; CtrlMDOp = op; InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
  endtask

  // Called #1 after the accept edge.
  task automatic wait_result(input string tag, input int lat_exp, input logic [31:0] val_exp);
    int lat = 1;
    while (!OutValid && lat < 200) begin
      @(posedge Clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_rd"}, Rd, val_exp);
    check({tag, "_inready_done"}, InReady, 0);
  endtask

  task automatic consume();
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    check("consume_outvalid", OutValid, 0);
    check("consume_rd_zero", Rd, 0);
    check("consume_inready", InReady, 1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] val_exp);
    start_op(op, a, b);
    wait_result(tag, exp_lat(32, op, {32'd0, a}, {32'd0, b}), val_exp);
    consume();
  endtask

  task automatic run_op8(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    int lat = 1;
    logic [63:0] r;
    r = ref_model(8, op, {56'd0, a}, {56'd0, b});
    check({tag, "_inready"}, InReady8, 1);
    Rs1_8 = a; Rs2_8 = b; Op8 = op; InValid8 = 1'b1;
    @(posedge Clk); #1;
    InValid8 = 1'b0;
    while (!OutValid8 && lat < 100) begin
      @(posedge Clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat(8, op, {56'd0, a}, {56'd0, b}));
    check({tag, "_rd"}, Rd8, r);
    OutReady8 = 1'b1;
    @(posedge Clk); #1;
    OutReady8 = 1'b0;
    check({tag, "_consumed"}, OutValid8, 0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, r;
  } vec_t;

  vec_t vecs [8] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
    '{3'd4, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF},
    '{3'd7, 32'h1234_5678,  32'd0,         32'h1234_5678},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000},
    '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF}
  };

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] r;
    bit          seen;

    ResetN = 1'b0;
    InValid = 0; Kill = 0; OutReady = 0; Rs1 = 0; Rs2 = 0; CtrlMDOp = 0;
    InValid8 = 0; Kill8 = 0; OutReady8 = 0; Rs1_8 = 0; Rs2_8 = 0; Op8 = 0;
    #12;
    check("reset_outvalid", OutValid, 0);
    check("reset_rd", Rd, 0);
    check("reset_inready", InReady, 1);
    check("reset_outvalid8", OutValid8, 0);
    ResetN = 1'b1;
    @(posedge Clk); #1;
    check("post_reset_inready", InReady, 1);

    foreach (vecs[i]) run_op($sformatf("dir%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r);

    // Hold in DONE for 10 cycles, then consume with a new request already waiting.
    start_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    wait_result("hold", 33, 32'h4000_0000);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      check("hold_rd", Rd, 32'h4000_0000);
      check("hold_outvalid", OutValid, 1);
      check("hold_inready", InReady, 0);
    end
    OutReady = 1'b1; InValid = 1'b1; Rs1 = 32'd7; Rs2 = 32'hFFFF_FFFD; CtrlMDOp = 3'd0;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    check("release_outvalid", OutValid, 0);
    check("release_no_accept", InReady, 1);
    @(posedge Clk); #1;
    InValid = 1'b0;
    check("accept_after_release", InReady, 0);
    wait_result("post_release", 33, 32'hFFFF_FFEB);
    consume();

    // Kill at iteration 5 of a DIVU.
    start_op(3'd5, 32'h1234_5678, 32'd7);
    repeat (5) @(posedge Clk);
    #1 Kill = 1'b1;
    @(posedge Clk); #1;
    Kill = 1'b0;
    check("kill_busy_inready", InReady, 1);
    seen = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (OutValid) seen = 1;
    end
    check("kill_busy_no_outvalid", seen, 0);

    // Kill beats a pending accept.
    InValid = 1'b1; Kill = 1'b1; Rs1 = 32'd9; Rs2 = 32'd3; CtrlMDOp = 3'd0;
    @(posedge Clk); #1;
    InValid = 1'b0; Kill = 1'b0;
    check("kill_blocks_accept", InReady, 1);

    // Kill in DONE discards the result without OutReady.
    start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("kill_done_pre", 33, 32'hFFFF_FFFE);
    Kill = 1'b1;
    @(posedge Clk); #1;
    Kill = 1'b0;
    check("kill_done_outvalid", OutValid, 0);
    check("kill_done_rd", Rd, 0);
    check("kill_done_inready", InReady, 1);

    // Asynchronous reset mid-BUSY and in DONE.
    start_op(3'd4, 32'd100, 32'd7);
    repeat (3) @(posedge Clk);
    #2 ResetN = 1'b0;
    #1;
    check("areset_busy_outvalid", OutValid, 0);
    check("areset_busy_rd", Rd, 0);
    check("areset_busy_inready", InReady, 1);
    #3 ResetN = 1'b1;
    @(posedge Clk); #1;
    check("areset_release_inready", InReady, 1);
    start_op(3'd6, 32'd100, 32'd7);
    wait_result("areset_done_pre", 33, 32'd2);
    #2 ResetN = 1'b0;
    #1;
    check("areset_done_outvalid", OutValid, 0);
    check("areset_done_rd", Rd, 0);
    #3 ResetN = 1'b1;
    @(posedge Clk); #1;
    check("areset_done_inready", InReady, 1);

    // Randomized operations against the reference model.
    for (int i = 0; i < 120; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      r  = ref_model(32, op, {32'd0, a}, {32'd0, b});
      run_op($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), op, a, b, r[31:0]);
    end

    // WIDTH=8 instance.
    run_op8("w8_mulhu_ff", 3'd3, 8'hFF, 8'hFF);
    check("w8_mulhu_ff_const", ref_model(8, 3'd3, 64'hFF, 64'hFF), 64'hFE);
    for (int i = 0; i < 40; i++) begin
      run_op8($sformatf("w8_rand%0d", i), 3'($urandom_range(0, 7)),
              8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
